// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and defaults for the register file access controller.
// State encoding is a plain 2-bit code so the FSM register is easy to probe.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;
    localparam state_t ST_WRITE = 2'd3;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Request side of the controller: operand read, operand return, writeback.
// The control unit is the master, the access controller is the slave.
interface regfile_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_rs;
    logic [ADDR_W-1:0] rd_rt;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output rd_valid, rd_rs, rd_rt,
        input  rd_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready
    );

    modport slave (
        input  rd_valid, rd_rs, rd_rt,
        output rd_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready
    );

endinterface

// File: rtl/regfile_access_ctrl.sv
// Sequences the 2R/1W register file for the multi-cycle datapath.
// Writes get a one-cycle enable pulse; reads return registered operands.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter bit ZERO_PROT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_access_ctrl_if.slave req,
    output logic [ADDR_W-1:0] rf_read_address_0,
    output logic [ADDR_W-1:0] rf_read_address_1,
    input  logic [DATA_W-1:0] rf_read_data_0,
    input  logic [DATA_W-1:0] rf_read_data_1,
    output logic [ADDR_W-1:0] rf_write_address_0,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ra0_q, ra0_d;
    logic [ADDR_W-1:0] ra1_q, ra1_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              opv_q, opv_d;

    logic idle;
    logic wb_acc;
    logic rd_acc;

    assign idle   = (state_q == ST_IDLE);
    assign wb_acc = idle && req.wb_valid;
    assign rd_acc = idle && req.rd_valid && !req.wb_valid;

    assign req.wb_ready = idle;
    assign req.rd_ready = idle && !req.wb_valid;
    assign req.op_valid = opv_q;
    assign req.op_a     = opa_q;
    assign req.op_b     = opb_q;

    assign rf_read_address_0  = ra0_q;
    assign rf_read_address_1  = ra1_q;
    assign rf_write_address_0 = wa_q;
    assign rf_write_data      = wd_q;
    assign rf_write_en        = we_q;
    assign busy               = !idle;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: writeback wins over read in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wb_acc)      state_d = ST_WRITE;
                else if (rd_acc) state_d = ST_READ;
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ:  state_d = ST_HOLD;
            ST_HOLD:  if (req.op_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output next-values: write pulse, latched addresses, captured operands
    always_comb begin
        ra0_d = ra0_q;
        ra1_d = ra1_q;
        wa_d  = wa_q;
        wd_d  = wd_q;
        we_d  = 1'b0;
        opa_d = opa_q;
        opb_d = opb_q;
        opv_d = opv_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wb_acc) begin
                    wa_d = req.wb_addr;
                    wd_d = req.wb_data;
                    we_d = !(ZERO_PROT && req.wb_addr == ZADDR);
                end else if (rd_acc) begin
                    ra0_d = req.rd_rs;
                    ra1_d = req.rd_rt;
                end
            end
            ST_READ: begin
                opa_d = (ZERO_PROT && ra0_q == ZADDR) ? '0 : rf_read_data_0;
                opb_d = (ZERO_PROT && ra1_q == ZADDR) ? '0 : rf_read_data_1;
                opv_d = 1'b1;
            end
            ST_HOLD: if (req.op_ready) opv_d = 1'b0;
            default: ;
        endcase
    end

    // Output registers; reset clears the write pulse and pending operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra0_q <= '0;
            ra1_q <= '0;
            wa_q  <= '0;
            wd_q  <= '0;
            we_q  <= 1'b0;
            opa_q <= '0;
            opb_q <= '0;
            opv_q <= 1'b0;
        end else begin
            ra0_q <= ra0_d;
            ra1_q <= ra1_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
            we_q  <= we_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            opv_q <= opv_d;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for the register file access controller.
// A behavioural register file sits on the rf_* side.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  ra0, ra1, wa;
    logic [31:0] rd0, rd1, wd;
    logic        we;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    regfile_access_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_access_ctrl #(.DATA_W(32), .ADDR_W(5), .ZERO_PROT(1'b1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (bus),
        .rf_read_address_0  (ra0),
        .rf_read_address_1  (ra1),
        .rf_read_data_0     (rd0),
        .rf_read_data_1     (rd1),
        .rf_write_address_0 (wa),
        .rf_write_en        (we),
        .rf_write_data      (wd),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Register file model; r0 holds junk so zero protection is visible
    logic [31:0] rf [32] = '{0: 32'hBAD0_BAD0, default: 32'h0};
    assign rd0 = rf[ra0];
    assign rd1 = rf[ra1];
    always @(posedge clk) if (we) rf[wa] <= wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write pulse stability: one cycle only, address/data unchanged as it falls
    logic        p_we = 1'b0;
    logic [4:0]  p_wa = '0;
    logic [31:0] p_wd = '0;
    always @(negedge clk) begin
        if (rst_n && p_we) begin
            chk("we_single", {31'b0, we}, 32'd0);
            chk("wa_stable", {27'b0, wa}, {27'b0, p_wa});
            chk("wd_stable", wd, p_wd);
        end
        p_we = rst_n ? we : 1'b0;
        p_wa = wa;
        p_wd = wd;
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_we"},   {31'b0, we}, 0);
        chk({nm, "_busy"}, {31'b0, busy}, 0);
        chk({nm, "_opv"},  {31'b0, bus.op_valid}, 0);
        chk({nm, "_opa"},  bus.op_a, 0);
        chk({nm, "_opb"},  bus.op_b, 0);
        chk({nm, "_ra0"},  {27'b0, ra0}, 0);
        chk({nm, "_ra1"},  {27'b0, ra1}, 0);
        chk({nm, "_wa"},   {27'b0, wa}, 0);
        chk({nm, "_wd"},   wd, 0);
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        for (int i = 0; i < 20 && !bus.wb_ready; i++) @(negedge clk);
        if (!bus.wb_ready) chk("wb_timeout", 1, 0);
        @(posedge clk);
        #1 bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("wb_en", {31'b0, we}, {31'b0, (a != 5'd0)});
        chk("wb_busy", {31'b0, busy}, 1);
        chk("wb_addr", {27'b0, wa}, {27'b0, a});
        chk("wb_data", wd, d);
        @(negedge clk);
        chk("wb_en_off", {31'b0, we}, 0);
        chk("wb_idle", {31'b0, busy}, 0);
    endtask

    task automatic rd_issue(input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_rs    = rs;
        bus.rd_rt    = rt;
        for (int i = 0; i < 20 && !bus.rd_ready; i++) @(negedge clk);
        if (!bus.rd_ready) chk("rd_timeout", 1, 0);
        @(posedge clk);
        #1 bus.rd_valid = 1'b0;
    endtask

    task automatic rd_collect(input logic [31:0] ea, input logic [31:0] eb, input int hold);
        @(negedge clk);
        chk("rd_read_opv", {31'b0, bus.op_valid}, 0);
        chk("rd_read_busy", {31'b0, busy}, 1);
        @(negedge clk);
        chk("rd_opv", {31'b0, bus.op_valid}, 1);
        chk("rd_opa", bus.op_a, ea);
        chk("rd_opb", bus.op_b, eb);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_opv", {31'b0, bus.op_valid}, 1);
            chk("bp_opa", bus.op_a, ea);
            chk("bp_opb", bus.op_b, eb);
            chk("bp_rdy", {30'b0, bus.rd_ready, bus.wb_ready}, 0);
        end
        bus.op_ready = 1'b1;
        @(posedge clk);
        #1 bus.op_ready = 1'b0;
        @(negedge clk);
        chk("rd_done_opv", {31'b0, bus.op_valid}, 0);
        chk("rd_done_busy", {31'b0, busy}, 0);
        chk("rd_keep_opa", bus.op_a, ea);
    endtask

    typedef struct {
        bit          is_wb;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] data;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vt [9];

    initial begin
        vt[0] = '{1'b1, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0, 32'h0};
        vt[1] = '{1'b0, 5'd5,  5'd0,  32'h0, 32'hDEAD_BEEF, 32'h0};
        vt[2] = '{1'b1, 5'd0,  5'd0,  32'h0000_1234, 32'h0, 32'h0};
        vt[3] = '{1'b0, 5'd0,  5'd5,  32'h0, 32'h0, 32'hDEAD_BEEF};
        vt[4] = '{1'b1, 5'd7,  5'd0,  32'h0000_00FF, 32'h0, 32'h0};
        vt[5] = '{1'b0, 5'd7,  5'd7,  32'h0, 32'h0000_00FF, 32'h0000_00FF};
        vt[6] = '{1'b1, 5'd31, 5'd0,  32'hFFFF_FFFF, 32'h0, 32'h0};
        vt[7] = '{1'b0, 5'd31, 5'd7,  32'h0, 32'hFFFF_FFFF, 32'h0000_00FF};
        vt[8] = '{1'b0, 5'd1,  5'd31, 32'h0, 32'h0, 32'hFFFF_FFFF};

        bus.rd_valid = 1'b0;
        bus.rd_rs    = '0;
        bus.rd_rt    = '0;
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;

        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rdy", {30'b0, bus.rd_ready, bus.wb_ready}, 32'd3);

        foreach (vt[i]) begin
            if (vt[i].is_wb) begin
                do_wb(vt[i].a0, vt[i].data);
            end else begin
                rd_issue(vt[i].a0, vt[i].a1);
                rd_collect(vt[i].ea, vt[i].eb, 0);
            end
        end

        // Simultaneous requests: writeback first, read sees its data
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd3;
        bus.wb_data  = 32'hA5A5_A5A5;
        bus.rd_valid = 1'b1;
        bus.rd_rs    = 5'd3;
        bus.rd_rt    = 5'd5;
        #1;
        chk("sim_rd_ready", {31'b0, bus.rd_ready}, 0);
        chk("sim_wb_ready", {31'b0, bus.wb_ready}, 1);
        @(posedge clk);
        #1 bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("sim_we", {31'b0, we}, 1);
        chk("sim_rd_wait", {31'b0, bus.rd_ready}, 0);
        for (int i = 0; i < 20 && !bus.rd_ready; i++) @(negedge clk);
        if (!bus.rd_ready) chk("sim_timeout", 1, 0);
        @(posedge clk);
        #1 bus.rd_valid = 1'b0;
        rd_collect(32'hA5A5_A5A5, 32'hDEAD_BEEF, 0);

        // Backpressure: consumer stalls 4 cycles
        rd_issue(5'd31, 5'd5);
        rd_collect(32'hFFFF_FFFF, 32'hDEAD_BEEF, 4);

        // Reset in the middle of a write pulse
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd9;
        bus.wb_data  = 32'h0000_0055;
        @(posedge clk);
        #1 bus.wb_valid = 1'b0;
        chk("mid_we_hi", {31'b0, we}, 1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        rd_issue(5'd5, 5'd31);
        rd_collect(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1);

        // Random writeback stream under the pulse monitor
        for (int i = 0; i < 12; i++) begin
            logic [4:0]  ra;
            logic [31:0] rdat;
            ra   = 5'($urandom_range(0, 31));
            rdat = $urandom;
            do_wb(ra, rdat);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
